// File: rtl/div_unit.sv
// div_unit: 32-bit multicycle restoring divider, one quotient bit per cycle,
// signed/unsigned modes, divide-by-zero short path and in-flight annul.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  // state  | meaning
  // FREE   | idle, outputs zero, waiting for start_i
  // BYZERO | divisor was zero, result forced to 0 on next edge
  // ON     | iterating, one restoring step per cycle (32 steps)
  // END    | result valid, held until start_i drops
  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BYZERO = 2'b01,
    ON     = 2'b10,
    END    = 2'b11
  } state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [64:0] work;
  logic [31:0] divisor;
  logic        neg_quot;
  logic        neg_rem;

  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [33:0] diff;
  logic        borrow;
  logic [31:0] quot_fin;
  logic [31:0] rem_fin;
  logic        unused_diff_bit;

  assign abs_a = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign abs_b = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

  // Partial remainder lives in work[64:32]; it can reach 2*divisor-1, so the
  // trial subtraction needs 33 magnitude bits plus a borrow bit.
  assign diff            = {1'b0, work[64:32]} - {2'b00, divisor};
  assign borrow          = diff[33];
  assign unused_diff_bit = diff[32];

  assign quot_fin = neg_quot ? (~work[31:0] + 32'd1)  : work[31:0];
  assign rem_fin  = neg_rem  ? (~work[64:33] + 32'd1) : work[64:33];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= FREE;
      cnt      <= '0;
      work     <= '0;
      divisor  <= '0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
      ready_o  <= 1'b0;
      result_o <= '0;
    end else begin
      case (state)
        FREE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            divisor  <= abs_b;
            neg_quot <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
            neg_rem  <= signed_div_i & opdata1_i[31];
            work     <= {32'd0, abs_a, 1'b0};
            cnt      <= '0;
            state    <= (opdata2_i == 32'd0) ? BYZERO : ON;
          end
        end
        BYZERO: begin
          ready_o  <= 1'b1;
          result_o <= '0;
          state    <= END;
        end
        ON: begin
          if (annul_i) begin
            ready_o  <= 1'b0;
            result_o <= '0;
            state    <= FREE;
          end else if (cnt != 6'd32) begin
            if (borrow)
              work <= {work[63:0], 1'b0};
            else
              work <= {diff[31:0], work[31:0], 1'b1};
            cnt <= cnt + 6'd1;
          end else begin
            ready_o  <= 1'b1;
            result_o <= {rem_fin, quot_fin};
            state    <= END;
          end
        end
        END: begin
          if (!start_i) begin
            ready_o  <= 1'b0;
            result_o <= '0;
            state    <= FREE;
          end
        end
        default: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          state    <= FREE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and randomized divisions checked against an
// arithmetic reference model (native 64-bit division).
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: truncating division on 64-bit integers, {rem, quot}.
  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one division from FREE; edge 1 is the first edge after this call.
  task automatic run_div(input string tag, input bit sgn, input logic [31:0] a,
                         input logic [31:0] b, input bit poke_end, output logic [63:0] got);
    logic [63:0] exp;
    int          lat;
    exp = ref_div(sgn, a, b);
    lat = (b == 32'd0) ? 2 : 34;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    for (int e = 1; e <= lat; e++) begin
      tick();
      if (e == 1) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = 1'($urandom);
      end
      if (e == lat - 1) chk({tag, "_early"}, {63'd0, ready_o}, 64'd0);
    end
    chk({tag, "_rdy"}, {63'd0, ready_o}, 64'd1);
    chk({tag, "_res"}, result_o, exp);
    got = result_o;
    if (poke_end) begin
      annul_i = 1'b1;
      tick();
      tick();
      chk({tag, "_end_annul_rdy"}, {63'd0, ready_o}, 64'd1);
      chk({tag, "_end_annul_res"}, result_o, exp);
      annul_i = 1'b0;
    end
    start_i = 1'b0;
    tick();
    chk({tag, "_drop_rdy"}, {63'd0, ready_o}, 64'd0);
    chk({tag, "_drop_res"}, result_o, 64'd0);
  endtask

  initial begin
    logic [63:0] got;
    logic        seen;
    logic [31:0] ra, rb;
    bit          rs;

    rst          = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    tick();
    tick();
    chk("reset_rdy", {63'd0, ready_o}, 64'd0);
    chk("reset_res", result_o, 64'd0);
    rst = 1'b1;
    tick();

    run_div("u100_7", 1'b0, 32'd100, 32'd7, 1'b0, got);
    chk("u100_7_const", got, 64'h00000002_0000000E);
    run_div("s_m8_3", 1'b1, 32'hFFFFFFF8, 32'h00000003, 1'b1, got);
    chk("s_m8_3_const", got, 64'hFFFFFFFE_FFFFFFFE);
    run_div("div0", 1'b0, 32'd5, 32'd0, 1'b0, got);
    chk("div0_const", got, 64'd0);
    run_div("ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, got);
    chk("ovf_const", got, 64'h00000000_80000000);

    // Annul at edge 10, start held so the next division follows directly.
    signed_div_i = 1'b0;
    opdata1_i    = 32'hFFFFFFFF;
    opdata2_i    = 32'd1;
    start_i      = 1'b1;
    seen         = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      tick();
      seen |= ready_o;
    end
    annul_i = 1'b1;
    tick();
    seen |= ready_o;
    chk("annul_never_rdy", {63'd0, seen}, 64'd0);
    chk("annul_res", result_o, 64'd0);
    run_div("after_annul", 1'b0, 32'd9, 32'd2, 1'b0, got);
    chk("after_annul_const", got, 64'h00000001_00000004);

    // Reset sampled at edge 20 of a division, held past where it would finish.
    signed_div_i = 1'b1;
    opdata1_i    = 32'h12345678;
    opdata2_i    = 32'h00000013;
    start_i      = 1'b1;
    for (int e = 1; e <= 19; e++) tick();
    rst = 1'b0;
    tick();
    chk("rst_mid_rdy", {63'd0, ready_o}, 64'd0);
    chk("rst_mid_res", result_o, 64'd0);
    seen = 1'b0;
    for (int e = 0; e < 20; e++) begin
      tick();
      seen |= ready_o;
    end
    chk("rst_hold_rdy", {63'd0, seen}, 64'd0);
    rst = 1'b1;
    run_div("post_rst", 1'b1, 32'h12345678, 32'h00000013, 1'b0, got);

    for (int i = 0; i < 24; i++) begin
      rs = 1'($urandom);
      ra = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = ($urandom_range(0, 1) == 0) ? 32'hFFFFFFFF : 32'h80000000;
        default: rb = $urandom;
      endcase
      run_div($sformatf("rnd%0d", i), rs, ra, rb, 1'($urandom), got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
